// File: rtl/promedio_ventana.sv
// Windowed averager over 2^K unsigned samples, selectable between block (tumbling)
// and moving (sliding) averages. out is floor(sum / 2^K); sum_ready pulses per result.
module promedio_ventana #(
  parameter int N = 16,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sum_en,
  input  logic         mode,
  input  logic         clear,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic         sum_ready,
  output logic [K:0]   fill
);

  localparam int         W         = 1 << K;
  localparam logic [K:0] FILL_FULL = (K+1)'(W);
  localparam logic [K:0] FILL_LAST = FILL_FULL - 1'b1;

  typedef enum logic {
    MODE_BLOCK  = 1'b0,
    MODE_MOVING = 1'b1
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [N+K-1:0]   acc_q, acc_d;
  logic [N-1:0]     win_q [W];
  logic [N-1:0]     win_d [W];
  logic [K-1:0]     wp_q, wp_d;
  logic [K:0]       fill_q, fill_d;
  logic [N-1:0]     out_q, out_d;
  logic             rdy_q, rdy_d;

  mode_e            mode_sel;
  logic             flush;
  logic [N+K-1:0]   in_ext;
  logic [N+K-1:0]   oldest;
  logic [N+K-1:0]   acc_upd;

  assign mode_sel = mode_e'(mode);
  assign flush    = en && (clear || (mode_sel != mode_q));
  assign in_ext   = {{K{1'b0}}, in};
  // Block mode never evicts; moving mode retires the sample about to be overwritten.
  // Modular N+K arithmetic is exact because the true window sum always fits.
  assign oldest   = (mode_q == MODE_MOVING) ? {{K{1'b0}}, win_q[wp_q]} : '0;
  assign acc_upd  = acc_q + in_ext - oldest;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    mode_d = mode_q;
    acc_d  = acc_q;
    win_d  = win_q;
    wp_d   = wp_q;
    fill_d = fill_q;
    out_d  = out_q;
    rdy_d  = 1'b0;

    if (flush) begin
      acc_d  = '0;
      wp_d   = '0;
      fill_d = '0;
      for (int i = 0; i < W; i++) win_d[i] = '0;
      mode_d = clear ? MODE_BLOCK : mode_sel;
      // A sample arriving with a mode switch seeds the new mode's first window.
      if (!clear && sum_en) begin
        acc_d  = in_ext;
        fill_d = (K+1)'(1);
        if (mode_sel == MODE_MOVING) begin
          win_d[0] = in;
          wp_d     = K'(1);
        end
      end
    end else if (en && sum_en) begin
      if (mode_q == MODE_BLOCK) begin
        if (fill_q == FILL_LAST) begin
          out_d  = acc_upd[N+K-1:K];
          rdy_d  = 1'b1;
          acc_d  = '0;
          fill_d = '0;
        end else begin
          acc_d  = acc_upd;
          fill_d = fill_q + 1'b1;
        end
      end else begin
        acc_d        = acc_upd;
        win_d[wp_q]  = in;
        wp_d         = wp_q + 1'b1;
        if (fill_q >= FILL_LAST) begin
          fill_d = FILL_FULL;
          out_d  = acc_upd[N+K-1:K];
          rdy_d  = 1'b1;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_BLOCK;
      acc_q  <= '0;
      wp_q   <= '0;
      fill_q <= '0;
      out_q  <= '0;
      rdy_q  <= 1'b0;
      // NOTE: the window buffer is reset explicitly because moving mode subtracts
      // stale entries from the sum; unknown contents would corrupt the average.
      for (int i = 0; i < W; i++) win_q[i] <= '0;
    end else begin
      mode_q <= mode_d;
      acc_q  <= acc_d;
      win_q  <= win_d;
      wp_q   <= wp_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
    end
  end

  assign out       = out_q;
  assign sum_ready = rdy_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_promedio_ventana.sv
// Bench for promedio_ventana (N=16, K=2): per-cycle vector table plus a result
// scoreboard, with a hand-driven asynchronous reset sequence mid-window.
module tb_promedio_ventana;

  localparam int N = 16;
  localparam int K = 2;

  typedef struct {
    logic         en;
    logic         sum_en;
    logic         mode;
    logic         clear;
    logic [N-1:0] din;
    logic         rdy;
    logic [N-1:0] dout;
    logic [K:0]   fill;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, sum_en, mode, clear;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic         sum_ready;
  logic [K:0]   fill;

  vec_t         vecs[$];
  logic [N-1:0] sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           split;

  always #5 clk = ~clk;

  promedio_ventana #(.N(N), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sum_en    (sum_en),
    .mode      (mode),
    .clear     (clear),
    .in        (din),
    .out       (dout),
    .sum_ready (sum_ready),
    .fill      (fill)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic a_en, input logic a_se, input logic a_mode,
                              input logic a_clr, input logic [N-1:0] a_din,
                              input logic a_rdy, input logic [N-1:0] a_dout,
                              input logic [K:0] a_fill);
    vec_t v;
    v.en = a_en; v.sum_en = a_se; v.mode = a_mode; v.clear = a_clr; v.din = a_din;
    v.rdy = a_rdy; v.dout = a_dout; v.fill = a_fill;
    vecs.push_back(v);
  endfunction

  task automatic apply(input int idx);
    vec_t v;
    logic [N-1:0] exp_res;
    v = vecs[idx];
    @(negedge clk);
    en = v.en; sum_en = v.sum_en; mode = v.mode; clear = v.clear; din = v.din;
    if (v.rdy) sb_q.push_back(v.dout);
    @(posedge clk);
    #1;
    check($sformatf("v%0d fill", idx), 32'(fill), 32'(v.fill));
    check($sformatf("v%0d sum_ready", idx), 32'(sum_ready), 32'(v.rdy));
    check($sformatf("v%0d out", idx), 32'(dout), 32'(v.dout));
    if (sum_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL v%0d scoreboard: sum_ready=1 with no result expected", idx);
      end else begin
        exp_res = sb_q.pop_front();
        check($sformatf("v%0d scoreboard result", idx), 32'(dout), 32'(exp_res));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Block mode: two windows.
    add(1,1,0,0, 100, 0,   0, 1);
    add(1,1,0,0, 200, 0,   0, 2);
    add(1,1,0,0, 300, 0,   0, 3);
    add(1,1,0,0, 400, 1, 250, 0);
    add(1,1,0,0, 250, 0, 250, 1);
    add(1,1,0,0, 260, 0, 250, 2);
    add(1,1,0,0, 240, 0, 250, 3);
    add(1,1,0,0, 270, 1, 255, 0);
    // Block mode with a three-cycle sum_en gap.
    add(1,1,0,0, 100, 0, 255, 1);
    add(1,1,0,0, 200, 0, 255, 2);
    add(1,0,0,0, 999, 0, 255, 2);
    add(1,0,0,0, 999, 0, 255, 2);
    add(1,0,0,0, 999, 0, 255, 2);
    add(1,1,0,0, 300, 0, 255, 3);
    add(1,1,0,0, 400, 1, 250, 0);
    // Truncation and full-scale width.
    add(1,1,0,0, 1, 0, 250, 1);
    add(1,1,0,0, 1, 0, 250, 2);
    add(1,1,0,0, 1, 0, 250, 3);
    add(1,1,0,0, 2, 1,   1, 0);
    add(1,1,0,0, 16'hFFFF, 0, 1, 1);
    add(1,1,0,0, 16'hFFFF, 0, 1, 2);
    add(1,1,0,0, 16'hFFFF, 0, 1, 3);
    add(1,1,0,0, 16'hFFFF, 1, 16'hFFFF, 0);
    // clear with a coincident sample, then en=0 mid-window.
    add(1,1,0,0, 5,  0, 16'hFFFF, 1);
    add(1,1,0,0, 7,  0, 16'hFFFF, 2);
    add(1,1,0,1, 99, 0, 16'hFFFF, 0);
    add(1,1,0,0, 8,  0, 16'hFFFF, 1);
    add(1,1,0,0, 8,  0, 16'hFFFF, 2);
    add(0,1,1,1, 500, 0, 16'hFFFF, 2);
    add(1,1,0,0, 8,  0, 16'hFFFF, 3);
    add(1,1,0,0, 8,  1, 8, 0);
    // Moving mode, entered with a sample in the switch cycle.
    add(1,1,1,0, 100, 0,   8, 1);
    add(1,1,1,0, 200, 0,   8, 2);
    add(1,1,1,0, 300, 0,   8, 3);
    add(1,1,1,0, 400, 1, 250, 4);
    add(1,1,1,0, 500, 1, 350, 4);
    add(1,1,1,0, 600, 1, 450, 4);
    add(0,1,0,1, 999, 0, 450, 4);
    add(1,1,1,0, 700, 1, 550, 4);
    add(1,0,1,0, 0,   0, 550, 4);
    // Switch 1->0 and 0->1, each carrying a sample.
    add(1,1,0,0, 10, 0, 550, 1);
    add(1,1,0,0, 20, 0, 550, 2);
    add(1,1,1,0, 40, 0, 550, 1);
    add(1,1,1,0, 41, 0, 550, 2);
    add(1,1,1,0, 42, 0, 550, 3);
    add(1,1,1,0, 43, 1,  41, 4);
    split = vecs.size();
    // After the mid-window reset: a fresh block window.
    add(1,1,0,0, 4, 0, 0, 1);
    add(1,1,0,0, 4, 0, 0, 2);
    add(1,1,0,0, 4, 0, 0, 3);
    add(1,1,0,0, 8, 1, 5, 0);

    reset = 1'b0; en = 1'b0; sum_en = 1'b0; mode = 1'b0; clear = 1'b0; din = '0;
    #1;
    check("reset out", 32'(dout), 32'd0);
    check("reset sum_ready", 32'(sum_ready), 32'd0);
    check("reset fill", 32'(fill), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < split; i++) apply(i);

    // Asynchronous reset between clock edges while out, fill and sum_ready are all nonzero.
    #2;
    reset = 1'b0;
    #1;
    check("async reset out", 32'(dout), 32'd0);
    check("async reset fill", 32'(fill), 32'd0);
    check("async reset sum_ready", 32'(sum_ready), 32'd0);
    @(negedge clk);
    en = 1'b1; sum_en = 1'b1; mode = 1'b1; din = 16'd77;
    @(posedge clk);
    #1;
    check("held reset fill", 32'(fill), 32'd0);
    check("held reset out", 32'(dout), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = split; i < vecs.size(); i++) apply(i);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/promedio_ventana.md
Name: promedio_ventana

Overview:
- Parametrised successor to the fixed-width block averager.
- Averages a stream of unsigned N-bit samples over a window of 2^K samples.
- Two run-time modes: block (tumbling) average and moving (sliding) average.
- Sits between the sample source and downstream consumers; sum_ready flags each new result.

Parameters:
- N, 16, sample and result width in bits.
- K, 2, log2 of window depth; window W = 2^K, K in 1..6.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0, all state holds and no sample is accepted.
- sum_en  in  1  sample valid; a sample is accepted on a clk edge with en=1 and sum_en=1.
- mode  in  1  0 = block average, 1 = moving average.
- clear  in  1  synchronous flush of accumulator, buffer and counters; effective only when en=1.
- in  in  N  unsigned sample.
- out  out  N  registered average = floor(sum / W).
- sum_ready  out  1  one-cycle pulse; out holds a new result.
- fill  out  K+1  number of valid samples in the current window, 0..W.

Behaviour:
- Reset (reset=0, async) values: out=0, sum_ready=0, fill=0, accumulator=0, all buffer entries=0, write pointer=0, mode_q=0.
- Accumulator width is N+K bits; it never overflows.
- out = accumulator >> K, truncating toward zero with no rounding.
- sum_ready is 0 in every cycle that does not follow a completing acceptance, including cycles with en=0.
- Priority (highest first): reset, clear, mode change, sample acceptance.
- clear with en=1:
  - Next state equals reset state, except out holds its last value.
  - A sample presented in the same cycle is discarded.
  - sum_ready=0 next cycle.
- Mode change (mode != mode_q with en=1):
  - mode_q is updated and the same flush as clear is applied.
  - If sum_en=1 in that cycle, the sample is accepted as the first sample of the new mode, so fill=1 afterwards.
- Block mode (mode_q=0):
  - Each accepted sample adds to the accumulator and increments fill.
  - When the W-th sample is accepted:
    - out <= (acc + in) >> K.
    - sum_ready=1 in the next cycle.
    - Accumulator and fill are cleared to 0 at the same edge.
  - Latency: 1 clk from the last sample edge to out/sum_ready.
  - Gaps in sum_ready/sum_en hold the partial sum; nothing is aborted.
- Moving mode (mode_q=1):
  - Circular buffer of W entries; pointer wp wraps from W-1 to 0.
  - On acceptance:
    - acc <= acc + in - buf[wp].
    - buf[wp] <= in.
    - wp <= wp + 1.
    - fill <= min(fill + 1, W).
  - Once fill reaches W (including on the acceptance that makes it W), every acceptance updates out to the new acc >> K and pulses sum_ready next cycle.
  - During warm-up (fill < W), out holds and sum_ready=0.
- en=0: no state changes, and clear, mode and sum_en are ignored.
- Reset asserted mid-window: everything returns immediately to reset values, and the partial window is lost.

Test Plan:
1. Block mode, N=16, K=2; feed 100, 200, 300, 400 with sum_en=1 -> out=250 with a single sum_ready pulse one cycle after the 400 edge; then 250, 260, 240, 270 -> out=255.
2. Block mode with a sum_en=0 gap of 3 cycles after 2 samples, then 2 more samples of 100, 200, 300, 400 -> out=250, fill stepping 1, 2, 2, 2, 2, 3, 0, and no spurious sum_ready.
3. Moving mode, K=2; feed 100, 200, 300, 400, 500, 600:
   - sum_ready=0 for the first 3 samples.
   - Results are 250, 350, 450 on consecutive cycles.
   - fill saturates at 4.
4. Truncation and width: block mode with 1, 1, 1, 2 -> out=1; with four samples of 0xFFFF -> out=0xFFFF and no wrap.
5. clear asserted together with sum_en after 2 samples -> fill=0, sample dropped, out unchanged; the next 4 samples of 8 -> out=8.
6. Mode switch 0->1 with a sample of 40 in the switch cycle -> fill=1; asynchronous reset pulse mid-window -> out=0, fill=0, sum_ready=0 immediately, independent of clk.
